// File: rtl/riscv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : riscv_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               controller state encoding, next-PC select codes and the
//               architectural register-index width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

  // Width of an architectural register index (x0..x31)
  localparam int REG_IDX_W = 5;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_CSR_DRAIN   = 2'd1,
    ST_MEM_WAIT    = 2'd2,
    ST_TRAP_SETTLE = 2'd3
  } ctrl_state_t;

  // Next-PC select codes
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_TRAP   = 2'b10;
  localparam logic [1:0] PC_MEPC   = 2'b11;

endpackage : riscv_ctrl_pkg

`default_nettype wire

// File: rtl/hazard_detect.sv
//------------------------------------------------------------------------------
// Module      : hazard_detect
// Description : Combinational detection of the load-use hazard (load in EX
//               feeding a source operand in ID) and the CSR read-after-write
//               hazard (CSR read in ID behind a CSR write in EX).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import riscv_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs1_id_i,
  input  logic [REG_IDX_W-1:0] rs2_id_i,
  input  logic [1:0]           rs_used_id_i,
  input  logic                 csr_rd_id_i,
  input  logic [REG_IDX_W-1:0] rd_ex_i,
  input  logic                 rd_enb_ex_i,
  input  logic                 csr_wr_ex_i,
  output logic                 load_use_o,
  output logic                 csr_haz_o
);

  logic rs1_hit;
  logic rs2_hit;

  // A source only conflicts if the decoded instruction actually reads it
  assign rs1_hit = rs_used_id_i[0] & (rs1_id_i == rd_ex_i);
  assign rs2_hit = rs_used_id_i[1] & (rs2_id_i == rd_ex_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign load_use_o = rd_enb_ex_i & (rd_ex_i != '0) & (rs1_hit | rs2_hit);

  assign csr_haz_o  = csr_rd_id_i & csr_wr_ex_i;

endmodule : hazard_detect

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush scheduler for the 5-stage pipeline.
//               Sequences load-use bubbles, CSR drains, memory wait states
//               with timeout, branch/mret redirects and trap entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CSR_DRAIN   = 2,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic [1:0]           rs_used_id,
  input  logic                 csr_rd_id,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 rd_enb_ex,
  input  logic                 csr_wr_ex,
  input  logic                 br_taken_ex,
  input  logic                 mret_ex,
  input  logic                 rd_enb_mem,
  input  logic                 wr_enb_mem,
  input  logic                 mem_ready,
  input  logic                 trap_req,
  output logic                 stall_pc,
  output logic                 stall_ifid,
  output logic                 stall_idex,
  output logic                 stall_exmem,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 flush_memwb,
  output logic [1:0]           pc_sel,
  output logic                 trap_ack,
  output logic                 mem_timeout
);

  localparam logic [2:0] DRAIN_LOAD   = 3'(CSR_DRAIN - 1);
  localparam logic [7:0] TIMEOUT_CNT  = 8'(MEM_TIMEOUT);

  ctrl_state_t state_q, state_d;
  logic [2:0]  drain_cnt_q, drain_cnt_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic csr_haz;
  logic mem_busy;
  logic run_rules;

  logic       stall_pc_c, stall_ifid_c, stall_idex_c, stall_exmem_c;
  logic       flush_ifid_c, flush_idex_c, flush_memwb_c;
  logic [1:0] pc_sel_c;
  logic       trap_ack_c, mem_timeout_c;

  hazard_detect u_hazard_detect (
    .rs1_id_i     (rs1_id),
    .rs2_id_i     (rs2_id),
    .rs_used_id_i (rs_used_id),
    .csr_rd_id_i  (csr_rd_id),
    .rd_ex_i      (rd_ex),
    .rd_enb_ex_i  (rd_enb_ex),
    .csr_wr_ex_i  (csr_wr_ex),
    .load_use_o   (load_use),
    .csr_haz_o    (csr_haz)
  );

  assign mem_busy = (rd_enb_mem | wr_enb_mem) & ~mem_ready;

  // Next-state, counter and control decode for every controller state
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    run_rules     = 1'b0;
    stall_pc_c    = 1'b0;
    stall_ifid_c  = 1'b0;
    stall_idex_c  = 1'b0;
    stall_exmem_c = 1'b0;
    flush_ifid_c  = 1'b0;
    flush_idex_c  = 1'b0;
    flush_memwb_c = 1'b0;
    pc_sel_c      = PC_PLUS4;
    trap_ack_c    = 1'b0;
    mem_timeout_c = 1'b0;

    case (state_q)
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt_q == TIMEOUT_CNT) begin
            // Give up on the access and vector to the trap handler
            mem_timeout_c = 1'b1;
            trap_ack_c    = 1'b1;
            pc_sel_c      = PC_TRAP;
            flush_ifid_c  = 1'b1;
            flush_idex_c  = 1'b1;
            flush_memwb_c = 1'b1;
            wait_cnt_d    = '0;
            state_d       = ST_TRAP_SETTLE;
          end else begin
            stall_pc_c    = 1'b1;
            stall_ifid_c  = 1'b1;
            stall_idex_c  = 1'b1;
            stall_exmem_c = 1'b1;
            flush_memwb_c = 1'b1;
            wait_cnt_d    = wait_cnt_q + 8'd1;
          end
        end else begin
          // Access completes: the pipeline moves again. A redirect or hazard
          // held in EX/ID during the wait is resolved now; a pending trap is
          // left for the following RUN cycle.
          wait_cnt_d = '0;
          state_d    = ST_RUN;
          run_rules  = 1'b1;
        end
      end

      ST_CSR_DRAIN: begin
        if (mem_busy) begin
          // Drain is abandoned; the CSR hazard re-detects once back in RUN
          stall_pc_c    = 1'b1;
          stall_ifid_c  = 1'b1;
          stall_idex_c  = 1'b1;
          stall_exmem_c = 1'b1;
          flush_memwb_c = 1'b1;
          drain_cnt_d   = '0;
          wait_cnt_d    = 8'd1;
          state_d       = ST_MEM_WAIT;
        end else if (trap_req) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          pc_sel_c     = PC_TRAP;
          trap_ack_c   = 1'b1;
          drain_cnt_d  = '0;
          state_d      = ST_TRAP_SETTLE;
        end else begin
          stall_pc_c   = 1'b1;
          stall_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          drain_cnt_d  = drain_cnt_q - 3'd1;
          if (drain_cnt_q == 3'd1) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        // ST_RUN and ST_TRAP_SETTLE share the rules; the settle cycle masks
        // trap_req so one request cannot be acknowledged twice in a row
        state_d = ST_RUN;
        if (mem_busy) begin
          stall_pc_c    = 1'b1;
          stall_ifid_c  = 1'b1;
          stall_idex_c  = 1'b1;
          stall_exmem_c = 1'b1;
          flush_memwb_c = 1'b1;
          wait_cnt_d    = 8'd1;
          state_d       = ST_MEM_WAIT;
        end else if (trap_req && (state_q == ST_RUN)) begin
          flush_ifid_c = 1'b1;
          flush_idex_c = 1'b1;
          pc_sel_c     = PC_TRAP;
          trap_ack_c   = 1'b1;
          state_d      = ST_TRAP_SETTLE;
        end else begin
          run_rules = 1'b1;
        end
      end
    endcase

    // Redirect and bubble rules shared by RUN, TRAP_SETTLE and wait exit.
    // A taken branch squashes the dependent instruction, so it beats load-use.
    if (run_rules) begin
      if (mret_ex || br_taken_ex) begin
        flush_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
        pc_sel_c     = mret_ex ? PC_MEPC : PC_BRANCH;
      end else if (csr_haz) begin
        stall_pc_c   = 1'b1;
        stall_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
        if (CSR_DRAIN > 1) begin
          drain_cnt_d = DRAIN_LOAD;
          state_d     = ST_CSR_DRAIN;
        end
      end else if (load_use) begin
        stall_pc_c   = 1'b1;
        stall_ifid_c = 1'b1;
        flush_idex_c = 1'b1;
      end
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  // While reset is held, front-end buffers are kept flushed and nothing stalls
  assign stall_pc    = rst ? 1'b0 : stall_pc_c;
  assign stall_ifid  = rst ? 1'b0 : stall_ifid_c;
  assign stall_idex  = rst ? 1'b0 : stall_idex_c;
  assign stall_exmem = rst ? 1'b0 : stall_exmem_c;
  assign flush_ifid  = rst | flush_ifid_c;
  assign flush_idex  = rst | flush_idex_c;
  assign flush_memwb = rst ? 1'b0 : flush_memwb_c;
  assign pc_sel      = rst ? PC_PLUS4 : pc_sel_c;
  assign trap_ack    = rst ? 1'b0 : trap_ack_c;
  assign mem_timeout = rst ? 1'b0 : mem_timeout_c;

endmodule : pipeline_hazard_ctrl

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_hazard_ctrl;
  import riscv_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic [1:0] rs_used_id;
  logic       csr_rd_id, rd_enb_ex, csr_wr_ex, br_taken_ex, mret_ex;
  logic       rd_enb_mem, wr_enb_mem, mem_ready, trap_req;
  logic       stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic       flush_ifid, flush_idex, flush_memwb;
  logic [1:0] pc_sel;
  logic       trap_ack, mem_timeout;

  int nchk;
  int nfail;

  // Observed controls: {stalls pc/ifid/idex/exmem, flushes ifid/idex/memwb, pc_sel, trap_ack, mem_timeout}
  logic [10:0] outs;
  assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                 flush_ifid, flush_idex, flush_memwb, pc_sel, trap_ack, mem_timeout};

  localparam logic [10:0] E_IDLE  = {4'b0000, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [10:0] E_RST   = {4'b0000, 3'b110, 2'b00, 1'b0, 1'b0};
  localparam logic [10:0] E_LU    = {4'b1100, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [10:0] E_MEMST = {4'b1111, 3'b001, 2'b00, 1'b0, 1'b0};
  localparam logic [10:0] E_TRAP  = {4'b0000, 3'b110, 2'b10, 1'b1, 1'b0};
  localparam logic [10:0] E_BR    = {4'b0000, 3'b110, 2'b01, 1'b0, 1'b0};
  localparam logic [10:0] E_MRET  = {4'b0000, 3'b110, 2'b11, 1'b0, 1'b0};
  localparam logic [10:0] E_TO    = {4'b0000, 3'b111, 2'b10, 1'b1, 1'b1};

  pipeline_hazard_ctrl #(
    .CSR_DRAIN   (2),
    .MEM_TIMEOUT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .rs_used_id  (rs_used_id),
    .csr_rd_id   (csr_rd_id),
    .rd_ex       (rd_ex),
    .rd_enb_ex   (rd_enb_ex),
    .csr_wr_ex   (csr_wr_ex),
    .br_taken_ex (br_taken_ex),
    .mret_ex     (mret_ex),
    .rd_enb_mem  (rd_enb_mem),
    .wr_enb_mem  (wr_enb_mem),
    .mem_ready   (mem_ready),
    .trap_req    (trap_req),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .stall_idex  (stall_idex),
    .stall_exmem (stall_exmem),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .flush_memwb (flush_memwb),
    .pc_sel      (pc_sel),
    .trap_ack    (trap_ack),
    .mem_timeout (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0; rs_used_id = 2'b00;
    csr_rd_id = 1'b0; rd_enb_ex = 1'b0; csr_wr_ex = 1'b0;
    br_taken_ex = 1'b0; mret_ex = 1'b0;
    rd_enb_mem = 1'b0; wr_enb_mem = 1'b0; mem_ready = 1'b0; trap_req = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    rd_enb_mem = 1'b1;
    trap_req = 1'b1;
    tick();
    #1;
    nchk++;
    if (outs !== E_RST) begin
      nfail++; $display("FAIL reset_forced: got %b exp %b", outs, E_RST);
    end
    tick();
    #1;
    nchk++;
    if (outs !== E_RST) begin
      nfail++; $display("FAIL reset_held: got %b exp %b", outs, E_RST);
    end
    clear_inputs();
    rst = 1'b0;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL reset_release_idle: got %b exp %b", outs, E_IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    rd_enb_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs_used_id = 2'b01;
    #1;
    nchk++;
    if (outs !== E_LU) begin
      nfail++; $display("FAIL load_use_rs1: got %b exp %b", outs, E_LU);
    end
    tick();
    // Bubble now in EX: the hazard is gone
    rd_enb_ex = 1'b0;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL load_use_one_cycle: got %b exp %b", outs, E_IDLE);
    end
    tick();
    rd_enb_ex = 1'b1; rs_used_id = 2'b00;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL load_use_unused: got %b exp %b", outs, E_IDLE);
    end
    tick();
    rs_used_id = 2'b01; rd_ex = 5'd0; rs1_id = 5'd0;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL load_use_x0: got %b exp %b", outs, E_IDLE);
    end
    tick();
    rd_ex = 5'd9; rs1_id = 5'd3; rs2_id = 5'd9; rs_used_id = 2'b10;
    #1;
    nchk++;
    if (outs !== E_LU) begin
      nfail++; $display("FAIL load_use_rs2: got %b exp %b", outs, E_LU);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_csr_drain();
    clear_inputs();
    csr_rd_id = 1'b1; csr_wr_ex = 1'b1;
    #1;
    nchk++;
    if (outs !== E_LU) begin
      nfail++; $display("FAIL csr_drain_c1: got %b exp %b", outs, E_LU);
    end
    tick();
    csr_wr_ex = 1'b0;
    #1;
    nchk++;
    if (outs !== E_LU) begin
      nfail++; $display("FAIL csr_drain_c2: got %b exp %b", outs, E_LU);
    end
    tick();
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL csr_drain_done: got %b exp %b", outs, E_IDLE);
    end
    tick();
    // Trap arriving mid-drain abandons the drain
    csr_rd_id = 1'b1; csr_wr_ex = 1'b1;
    tick();
    csr_wr_ex = 1'b0; trap_req = 1'b1;
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL csr_drain_trap: got %b exp %b", outs, E_TRAP);
    end
    tick();
    clear_inputs();
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL csr_trap_settle: got %b exp %b", outs, E_IDLE);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    rd_enb_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) trap_req = 1'b1;
      #1;
      nchk++;
      if (outs !== E_MEMST) begin
        nfail++; $display("FAIL mem_wait_stall%0d: got %b exp %b", i, outs, E_MEMST);
      end
      tick();
    end
    // Completion cycle: no stall, trap still deferred
    mem_ready = 1'b1;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL mem_wait_done: got %b exp %b", outs, E_IDLE);
    end
    tick();
    rd_enb_mem = 1'b0; mem_ready = 1'b0;
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL mem_wait_trap_after: got %b exp %b", outs, E_TRAP);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    clear_inputs();
    wr_enb_mem = 1'b1;
    #1;
    nchk++;
    if (outs !== E_MEMST) begin
      nfail++; $display("FAIL timeout_enter: got %b exp %b", outs, E_MEMST);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      #1;
      nchk++;
      if (outs !== E_MEMST) begin
        nfail++; $display("FAIL timeout_wait%0d: got %b exp %b", i, outs, E_MEMST);
      end
    end
    tick();
    #1;
    nchk++;
    if (outs !== E_TO) begin
      nfail++; $display("FAIL timeout_pulse: got %b exp %b", outs, E_TO);
    end
    tick();
    // Settle cycle masks a fresh trap request
    wr_enb_mem = 1'b0; trap_req = 1'b1;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL timeout_settle_mask: got %b exp %b", outs, E_IDLE);
    end
    tick();
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL timeout_then_trap: got %b exp %b", outs, E_TRAP);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_trap_vs_branch();
    clear_inputs();
    trap_req = 1'b1; br_taken_ex = 1'b1;
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL trap_over_branch: got %b exp %b", outs, E_TRAP);
    end
    tick();
    br_taken_ex = 1'b0;
    #1;
    nchk++;
    if (outs !== E_IDLE) begin
      nfail++; $display("FAIL trap_no_double_ack: got %b exp %b", outs, E_IDLE);
    end
    tick();
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL trap_retaken: got %b exp %b", outs, E_TRAP);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_redirect();
    clear_inputs();
    mret_ex = 1'b1; br_taken_ex = 1'b1;
    #1;
    nchk++;
    if (outs !== E_MRET) begin
      nfail++; $display("FAIL mret_over_branch: got %b exp %b", outs, E_MRET);
    end
    tick();
    mret_ex = 1'b0;
    #1;
    nchk++;
    if (outs !== E_BR) begin
      nfail++; $display("FAIL branch_taken: got %b exp %b", outs, E_BR);
    end
    tick();
    // Branch coincident with load-use: redirect, no stall
    rd_enb_ex = 1'b1; rd_ex = 5'd7; rs1_id = 5'd7; rs_used_id = 2'b01;
    #1;
    nchk++;
    if (outs !== E_BR) begin
      nfail++; $display("FAIL branch_over_load_use: got %b exp %b", outs, E_BR);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midwait();
    clear_inputs();
    rd_enb_mem = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    nchk++;
    if (dut.wait_cnt_q !== 8'd7) begin
      nfail++; $display("FAIL midwait_cnt: got %0d exp 7", dut.wait_cnt_q);
    end
    rst = 1'b1;
    #1;
    nchk++;
    if (outs !== E_RST) begin
      nfail++; $display("FAIL midwait_rst_out: got %b exp %b", outs, E_RST);
    end
    tick();
    nchk++;
    if (dut.state_q !== ST_RUN || dut.wait_cnt_q !== 8'd0) begin
      nfail++; $display("FAIL midwait_rst_state: got state %0d cnt %0d exp 0 0",
                        dut.state_q, dut.wait_cnt_q);
    end
    nchk++;
    if (outs !== E_RST) begin
      nfail++; $display("FAIL midwait_rst_held: got %b exp %b", outs, E_RST);
    end
    rst = 1'b0; rd_enb_mem = 1'b0; trap_req = 1'b1;
    #1;
    nchk++;
    if (outs !== E_TRAP) begin
      nfail++; $display("FAIL midwait_run_after: got %b exp %b", outs, E_TRAP);
    end
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_csr_drain();
    test_mem_wait();
    test_timeout();
    test_trap_vs_branch();
    test_redirect();
    test_reset_midwait();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage RISC-V pipeline. It watches decode, execute and memory-stage control bits and the data-memory ready line. It drives hold/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers, plus the next-PC select. It sequences load-use bubbles, CSR read-after-write drains, memory wait states with timeout, branch/mret redirects and trap entry.

Parameters:
CSR_DRAIN, 2, bubble cycles inserted when a CSR read in ID follows a CSR write in EX (1..7)
MEM_TIMEOUT, 16, max consecutive memory-wait cycles before a timeout trap (2..255)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rs1_id  in  5  decode source register 1
rs2_id  in  5  decode source register 2
rs_used_id  in  2  bit0 = rs1 read, bit1 = rs2 read
csr_rd_id  in  1  decode instruction reads a CSR
rd_ex  in  5  execute destination register
rd_enb_ex  in  1  execute instruction is a load
csr_wr_ex  in  1  execute instruction writes a CSR
br_taken_ex  in  1  branch/jump resolved taken in EX
mret_ex  in  1  mret in EX
rd_enb_mem  in  1  load in MEM
wr_enb_mem  in  1  store in MEM
mem_ready  in  1  data memory completes this cycle
trap_req  in  1  pending interrupt/exception (level)
stall_pc  out  1  PC holds
stall_ifid  out  1  IF/ID holds
stall_idex  out  1  ID/EX holds
stall_exmem  out  1  EX/MEM holds
flush_ifid  out  1  IF/ID loads bubble
flush_idex  out  1  ID/EX loads bubble
flush_memwb  out  1  MEM/WB loads bubble
pc_sel  out  2  00 pc+4, 01 branch target, 10 trap vector, 11 mepc
trap_ack  out  1  one-cycle trap-taken pulse
mem_timeout  out  1  one-cycle timeout pulse

Behaviour:
- Registered state: RUN, CSR_DRAIN, MEM_WAIT, TRAP_SETTLE. Registered counters: drain_cnt (3 bits) and wait_cnt (8 bits). All outputs are combinational from the state and inputs.
- When rst=1 at a clock edge: state goes to RUN and both counters clear.
- While rst=1, outputs are forced to: all stalls 0, flush_ifid=1, flush_idex=1, flush_memwb=0, pc_sel=00, trap_ack=0, mem_timeout=0. The same values apply on the first cycle after reset if rst is held.
- Stall meaning: the buffer keeps its value. Flush meaning: the buffer loads all-zero control. When stall and flush are both set on a buffer, flush wins.
- mem_busy = (rd_enb_mem | wr_enb_mem) & !mem_ready.
- load_use = rd_enb_ex & rd_ex!=0 & ((rs_used_id[0] & rs1_id==rd_ex) | (rs_used_id[1] & rs2_id==rd_ex)).
- RUN priority, highest first:
  1. mem_busy: stall_pc/ifid/idex/exmem=1, flush_memwb=1. Go to MEM_WAIT, wait_cnt=1.
  2. trap_req: flush_ifid=1, flush_idex=1, pc_sel=10, trap_ack=1. Go to TRAP_SETTLE.
  3. mret_ex or br_taken_ex: flush_ifid=1, flush_idex=1, pc_sel=11 (mret) or 01 (branch). mret beats branch. Stay in RUN.
  4. csr_rd_id & csr_wr_ex: stall_pc=1, stall_ifid=1, flush_idex=1. Go to CSR_DRAIN with drain_cnt=CSR_DRAIN-1. If CSR_DRAIN=1, stay in RUN.
  5. load_use: stall_pc=1, stall_ifid=1, flush_idex=1 for exactly one cycle. Stay in RUN.
  6. Otherwise all controls 0, pc_sel=00.
- CSR_DRAIN:
  - Each cycle: stall_pc=1, stall_ifid=1, flush_idex=1, drain_cnt decrements.
  - At drain_cnt==1, return to RUN.
  - A trap_req here wins: apply the trap response, go to TRAP_SETTLE, abandon the drain.
  - mem_busy here wins over the trap: stall as in MEM_WAIT and go to MEM_WAIT; the drain is abandoned and the hazard re-detects in RUN.
- MEM_WAIT:
  - While mem_busy: full stall plus flush_memwb=1, wait_cnt increments.
  - When mem_ready=1: no stall, go to RUN, wait_cnt clears. The instruction in MEM completes this cycle.
  - If wait_cnt==MEM_TIMEOUT with mem_busy still high: mem_timeout=1, trap_ack=1, pc_sel=10, flush_ifid=1, flush_idex=1, flush_memwb=1. Go to TRAP_SETTLE.
  - trap_req is ignored in MEM_WAIT and serviced in RUN afterwards.
- TRAP_SETTLE:
  - Lasts one cycle. trap_req is masked, so no second trap_ack. Branch, load-use and CSR rules act as in RUN. Next state is RUN.
  - mem_busy here moves to MEM_WAIT.
- A branch in EX coincident with load_use: the branch rule applies and no stall occurs.
- A trap_req high for N cycles produces at most one trap_ack every 2 cycles.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the ctrl_state_t enum (RUN, CSR_DRAIN, MEM_WAIT, TRAP_SETTLE);
  - the pc_sel localparams PC_PLUS4, PC_BRANCH, PC_TRAP, PC_MEPC;
  - the register-index width (5).
- One combinational sub-module, hazard_detect, computes load_use and the CSR hazard. The FSM, counters and output decode live in pipeline_hazard_ctrl.

Test Plan:
- Load-use: rd_enb_ex=1, rd_ex=5, rs1_id=5, rs_used_id=01 -> stall_pc=stall_ifid=flush_idex=1 for exactly 1 cycle; rs_used_id=00 or rd_ex=0 -> no stall.
- CSR drain: csr_rd_id=1 and csr_wr_ex=1 in one cycle, CSR_DRAIN=2 -> flush_idex high for 2 consecutive cycles, then RUN with zero stalls.
- Memory wait: rd_enb_mem=1, mem_ready low 3 cycles then high -> 3 cycles of full stall with flush_memwb=1, zero stall on the 4th cycle; with mem_ready never high -> mem_timeout and trap_ack pulse on cycle 16, pc_sel=10.
- Trap vs branch: trap_req=1 and br_taken_ex=1 together -> pc_sel=10, trap_ack=1; next cycle with trap_req still 1 -> trap_ack=0, then re-taken on the following cycle.
- mret_ex=1 with br_taken_ex=1 -> pc_sel=11, flush_ifid=flush_idex=1.
- rst asserted during MEM_WAIT at wait_cnt=7 -> next cycle state RUN, wait_cnt=0, all stalls 0, flush_ifid=flush_idex=1 while rst is high.
